// File: rtl/ysyx_25040111_axi_pkg.sv
// Shared types and AXI4 constants for the two-master arbiter.
// The state encoding is fixed here so every user agrees on the 2-bit values.
package ysyx_25040111_axi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IFU_R = 2'd1;
  localparam logic [1:0] ST_LSU_R = 2'd2;
  localparam logic [1:0] ST_LSU_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    IFU_R = ST_IFU_R,
    LSU_R = ST_LSU_R,
    LSU_W = ST_LSU_W
  } arb_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'h00;
  localparam logic [3:0] ID_ZERO    = 4'h0;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Fixed-priority grant: a pending write beats an LSU read, which beats a fetch.
  function automatic arb_state_t grant(input logic aw_req, input logic ar_req,
                                       input logic if_req);
    if (aw_req)      return LSU_W;
    else if (ar_req) return LSU_R;
    else if (if_req) return IFU_R;
    else             return IDLE;
  endfunction

endpackage

// File: rtl/ysyx_25040111_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter.
// One single-beat transaction owns the bus at a time; the owner is muxed through combinationally.
module ysyx_25040111_axi_arbiter
  import ysyx_25040111_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  input  logic                io_master_awready,
  output logic                io_master_awvalid,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [3:0]          io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  input  logic                io_master_wready,
  output logic                io_master_wvalid,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  output logic                io_master_bready,
  input  logic                io_master_bvalid,
  input  logic [1:0]          io_master_bresp,
  input  logic                io_master_arready,
  output logic                io_master_arvalid,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [3:0]          io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  output logic                io_master_rready,
  input  logic                io_master_rvalid,
  input  logic [1:0]          io_master_rresp,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic                io_master_rlast
);

  arb_state_t state_reg, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    ifu_arready       = 1'b0;
    ifu_rvalid        = 1'b0;
    ifu_rdata         = '0;
    ifu_rresp         = '0;
    lsu_arready       = 1'b0;
    lsu_rvalid        = 1'b0;
    lsu_rdata         = '0;
    lsu_rresp         = '0;
    lsu_awready       = 1'b0;
    lsu_wready        = 1'b0;
    lsu_bvalid        = 1'b0;
    lsu_bresp         = '0;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = '0;
    io_master_awid    = '0;
    io_master_awlen   = '0;
    io_master_awsize  = '0;
    io_master_awburst = '0;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arid    = '0;
    io_master_arlen   = '0;
    io_master_arsize  = '0;
    io_master_arburst = '0;
    io_master_rready  = 1'b0;

    unique case (state_reg)
      IDLE: state_next = grant(lsu_awvalid, lsu_arvalid, ifu_arvalid);
      IFU_R: begin
        io_master_arvalid = ifu_arvalid;
        io_master_araddr  = ifu_araddr;
        io_master_arid    = ID_ZERO;
        io_master_arlen   = LEN_SINGLE;
        io_master_arsize  = SIZE_WORD;
        io_master_arburst = BURST_INCR;
        ifu_arready       = io_master_arready;
        io_master_rready  = ifu_rready;
        ifu_rvalid        = io_master_rvalid;
        ifu_rdata         = io_master_rdata;
        ifu_rresp         = io_master_rresp;
        if (io_master_rvalid && ifu_rready && io_master_rlast) state_next = IDLE;
      end
      LSU_R: begin
        io_master_arvalid = lsu_arvalid;
        io_master_araddr  = lsu_araddr;
        io_master_arid    = ID_ZERO;
        io_master_arlen   = LEN_SINGLE;
        io_master_arsize  = lsu_arsize;
        io_master_arburst = BURST_INCR;
        lsu_arready       = io_master_arready;
        io_master_rready  = lsu_rready;
        lsu_rvalid        = io_master_rvalid;
        lsu_rdata         = io_master_rdata;
        lsu_rresp         = io_master_rresp;
        if (io_master_rvalid && lsu_rready && io_master_rlast) state_next = IDLE;
      end
      LSU_W: begin
        // AW and W are independent here; the slave may accept them in any order.
        io_master_awvalid = lsu_awvalid;
        io_master_awaddr  = lsu_awaddr;
        io_master_awid    = ID_ZERO;
        io_master_awlen   = LEN_SINGLE;
        io_master_awsize  = lsu_awsize;
        io_master_awburst = BURST_INCR;
        lsu_awready       = io_master_awready;
        io_master_wvalid  = lsu_wvalid;
        io_master_wdata   = lsu_wdata;
        io_master_wstrb   = lsu_wstrb;
        io_master_wlast   = lsu_wlast;
        lsu_wready        = io_master_wready;
        io_master_bready  = lsu_bready;
        lsu_bvalid        = io_master_bvalid;
        lsu_bresp         = io_master_bresp;
        if (io_master_bvalid && lsu_bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
